// File: rtl/dram_sched_pkg.sv
// dram_sched_pkg: shared FSM states, address field positions and DRAM pin idle values
package dram_sched_pkg;
   typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_RD, S_WR, S_RSP} state_e;
   localparam int ROW_MSB = 22;
   localparam int ROW_LSB = 12;
   localparam int COL_MSB = 11;
   localparam int COL_LSB = 2;
   localparam int ROW_W = ROW_MSB - ROW_LSB + 1;
   localparam int COL_W = COL_MSB - COL_LSB + 1;
   localparam logic PIN_STROBE_IDLE = 1'b1;
   localparam logic [3:0] PIN_WEN_IDLE = 4'hf;
   function automatic logic [ROW_W-1:0] row_of(input logic [31:0] addr);
      return ROW_W'(addr >> ROW_LSB);
   endfunction
   function automatic logic [COL_W-1:0] col_of(input logic [31:0] addr);
      return COL_W'(addr >> COL_LSB);
   endfunction
endpackage

// File: rtl/dram_rr_arbiter.sv
// dram_rr_arbiter: two-way round-robin grant; the pointer names the port preferred on a tie
module dram_rr_arbiter (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic [1:0] valid_i,
   output logic [1:0] gnt_o,
   output logic       idx_o
);
   logic ptr_q, ptr_d;
   always_comb begin
      idx_o = valid_i[1] && (!valid_i[0] || ptr_q);
      gnt_o = en_i && |valid_i ? (idx_o ? 2'b10 : 2'b01) : 2'b00;
      ptr_d = |gnt_o ? !idx_o : ptr_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) ptr_q <= 1'b0;
      else ptr_q <= ptr_d;
endmodule

// File: rtl/dram_req_scheduler.sv
// dram_req_scheduler: two-port DRAM scheduler with open-page policy and fixed-timing
// ACT/RD/WR/PRE sequencing; pins are registered from the next-state decode.
module dram_req_scheduler
   import dram_sched_pkg::*;
#(
   parameter int T_RCD      = 5,
   parameter int T_WR       = 5,
   parameter int T_RP       = 5,
   parameter int IDLE_CLOSE = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [1:0]       req_valid_i,
   input  logic [1:0]       req_write_i,
   input  logic [1:0][31:0] req_addr_i,
   input  logic [1:0][3:0]  req_wstrb_i,
   input  logic [1:0][31:0] req_wdata_i,
   output logic [1:0]       req_ready_o,
   output logic [1:0]       rsp_valid_o,
   output logic [31:0]      rsp_rdata_o,
   output logic             dram_csn_o,
   output logic             dram_rasn_o,
   output logic             dram_casn_o,
   output logic [3:0]       dram_wen_o,
   output logic [10:0]      dram_a_o,
   output logic [31:0]      dram_d_o,
   input  logic             dram_valid_i,
   input  logic [31:0]      dram_q_i
);
   state_e state_q, state_d;
   logic [4:0] cnt_q, cnt_d, idle_q, idle_d;
   logic row_open_q, row_open_d, pend_q, pend_d, wr_q, wr_d, g_q, g_d, gidx, first;
   logic [ROW_W-1:0] open_row_q, open_row_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, d_q, d_d;
   logic [3:0] wstrb_q, wstrb_d, wen_q, wen_d;
   logic [1:0] rsp_q, rsp_d;
   logic csn_q, rasn_q, rasn_d, casn_q, casn_d;
   logic [10:0] a_q, a_d;

   dram_rr_arbiter u_arb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (state_q == S_IDLE),
      .valid_i (req_valid_i),
      .gnt_o   (req_ready_o),
      .idx_o   (gidx)
   );

   always_comb begin
      state_d = state_q;
      row_open_d = row_open_q;
      open_row_d = open_row_q;
      pend_d = pend_q;
      wr_d = wr_q;
      addr_d = addr_q;
      wstrb_d = wstrb_q;
      wdata_d = wdata_q;
      g_d = g_q;
      rdata_d = rdata_q;
      idle_d = '0;
      unique case (state_q)
         S_IDLE:
            if (|req_valid_i) begin
               wr_d = req_write_i[gidx];
               addr_d = req_addr_i[gidx];
               wstrb_d = req_wstrb_i[gidx];
               wdata_d = req_wdata_i[gidx];
               g_d = gidx;
               pend_d = 1'b1;
               state_d = !row_open_q ? S_ACT :
                         row_of(req_addr_i[gidx]) != open_row_q ? S_PRE :
                         req_write_i[gidx] ? S_WR : S_RD;
            end else if (row_open_q) begin
               idle_d = idle_q + 5'd1;
               if (idle_q == 5'(IDLE_CLOSE - 1)) state_d = S_PRE;
            end
         S_PRE:
            if (cnt_q == 5'(T_RP - 1)) begin
               row_open_d = 1'b0;
               state_d = pend_q ? S_ACT : S_IDLE;
            end
         S_ACT:
            if (cnt_q == 5'(T_RCD - 1)) begin
               row_open_d = 1'b1;
               open_row_d = row_of(addr_q);
               state_d = wr_q ? S_WR : S_RD;
            end
         S_RD:
            if (dram_valid_i) begin
               rdata_d = dram_q_i;
               state_d = S_RSP;
            end
         S_WR: if (cnt_q == 5'(T_WR - 1)) state_d = S_RSP;
         S_RSP: begin
            pend_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
      // every command is issued on the first cycle of its state
      first = state_d != state_q;
      cnt_d = first ? '0 : &cnt_q ? cnt_q : cnt_q + 5'd1;
      rasn_d = !(first && (state_d == S_PRE || state_d == S_ACT));
      casn_d = !(first && (state_d == S_RD || state_d == S_WR));
      wen_d = first && state_d == S_PRE ? 4'h0 : first && state_d == S_WR ? wstrb_d : PIN_WEN_IDLE;
      a_d = first && state_d == S_PRE ? open_row_q : !casn_d ? {1'b0, col_of(addr_d)} : row_of(addr_d);
      d_d = first && state_d == S_WR ? wdata_d : '0;
      rsp_d = state_d == S_RSP ? (g_d ? 2'b10 : 2'b01) : 2'b00;
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         idle_q <= '0;
         row_open_q <= 1'b0;
         open_row_q <= '0;
         pend_q <= 1'b0;
         wr_q <= 1'b0;
         addr_q <= '0;
         wstrb_q <= PIN_WEN_IDLE;
         wdata_q <= '0;
         g_q <= 1'b0;
         rdata_q <= '0;
         rsp_q <= '0;
         csn_q <= 1'b1;
         rasn_q <= PIN_STROBE_IDLE;
         casn_q <= PIN_STROBE_IDLE;
         wen_q <= PIN_WEN_IDLE;
         a_q <= '0;
         d_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         idle_q <= idle_d;
         row_open_q <= row_open_d;
         open_row_q <= open_row_d;
         pend_q <= pend_d;
         wr_q <= wr_d;
         addr_q <= addr_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
         g_q <= g_d;
         rdata_q <= rdata_d;
         rsp_q <= rsp_d;
         csn_q <= 1'b0;
         rasn_q <= rasn_d;
         casn_q <= casn_d;
         wen_q <= wen_d;
         a_q <= a_d;
         d_q <= d_d;
      end

   assign rsp_valid_o = rsp_q;
   assign rsp_rdata_o = rdata_q;
   assign dram_csn_o = csn_q;
   assign dram_rasn_o = rasn_q;
   assign dram_casn_o = casn_q;
   assign dram_wen_o = wen_q;
   assign dram_a_o = a_q;
   assign dram_d_o = d_q;
endmodule

// File: tb/tb_dram_req_scheduler.sv
// tb_dram_req_scheduler: randomized transactions against a transaction-level timing and
// memory model, plus a pin-level DRAM responder that returns read data LAT cycles after CAS.
module tb_dram_req_scheduler;
   localparam int T_RCD = 5, T_WR = 5, T_RP = 5, IDLE_CLOSE = 16, LAT = 5;
   typedef struct {int cyc; logic [10:0] a; logic [3:0] wen; logic [31:0] d;} pin_ev_t;

   logic clk = 0, rst_n = 0;
   logic [1:0] req_valid = 0, req_write = 0, req_ready, rsp_valid;
   logic [1:0][31:0] req_addr = 0, req_wdata = 0;
   logic [1:0][3:0] req_wstrb = 0;
   logic [31:0] rsp_rdata, dram_d, dram_q = 0;
   logic dram_csn, dram_rasn, dram_casn, dram_valid = 0;
   logic [3:0] dram_wen;
   logic [10:0] dram_a;

   int cyc = 0, n_chk = 0, n_fail = 0, rsp_cnt = 0, last_rsp = 0, m_last = 1, rd_due = 0, dk;
   bit twohot = 0, m_open = 0, rd_pend = 0;
   logic [10:0] m_row = 0, act_row = 0;
   logic [31:0] rd_dat = 0, dw;
   pin_ev_t ras_q[$], cas_q[$];
   logic [31:0] dmem[int], rmem[int];

   dram_req_scheduler dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wstrb_i(req_wstrb), .req_wdata_i(req_wdata),
      .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
      .dram_csn_o(dram_csn), .dram_rasn_o(dram_rasn), .dram_casn_o(dram_casn),
      .dram_wen_o(dram_wen), .dram_a_o(dram_a), .dram_d_o(dram_d),
      .dram_valid_i(dram_valid), .dram_q_i(dram_q)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int mkey(logic [10:0] r, logic [9:0] c);
      return int'({11'b0, r, c});
   endfunction
   function automatic logic [31:0] init_word(int k);
      return (32'(k) * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction
   function automatic logic [31:0] rmem_rd(int k);
      return rmem.exists(k) ? rmem[k] : init_word(k);
   endfunction
   function automatic logic [85:0] outs();
      return {req_ready, rsp_valid, rsp_rdata, dram_csn, dram_rasn, dram_casn, dram_wen, dram_a, dram_d};
   endfunction
   localparam logic [85:0] RST_OUTS = {2'b0, 2'b0, 32'h0, 1'b1, 1'b1, 1'b1, 4'hf, 11'h0, 32'h0};

   // external DRAM model and pin monitor
   always @(negedge clk) begin
      dram_valid = 0;
      if (rd_pend && cyc == rd_due) begin
         dram_valid = 1;
         dram_q = rd_dat;
         rd_pend = 0;
      end
      if (rst_n) begin
         if (!dram_rasn) begin
            ras_q.push_back('{cyc, dram_a, dram_wen, dram_d});
            if (&dram_wen) act_row = dram_a;
         end
         if (!dram_casn) begin
            cas_q.push_back('{cyc, dram_a, dram_wen, dram_d});
            dk = mkey(act_row, dram_a[9:0]);
            dw = dmem.exists(dk) ? dmem[dk] : init_word(dk);
            if (&dram_wen) begin
               rd_pend = 1;
               rd_due = cyc + LAT;
               rd_dat = dw;
            end else begin
               for (int b = 0; b < 4; b++) if (!dram_wen[b]) dw[8*b +: 8] = dram_d[8*b +: 8];
               dmem[dk] = dw;
            end
         end
         if (&req_ready) twohot = 1;
         if (|rsp_valid) rsp_cnt++;
      end
   end

   task automatic xact(input int p, input bit wr, input logic [31:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, input int gap);
      int acc, got, cas_at, rsp_at, k;
      pin_ev_t exp_ras[$];
      logic [10:0] row;
      logic [9:0] col;
      logic [31:0] exp_d;
      row = addr[22:12];
      col = addr[11:2];
      k = mkey(row, col);
      repeat (gap + 1) @(posedge clk);
      #1;
      ras_q.delete();
      cas_q.delete();
      req_write[p] = wr; req_addr[p] = addr; req_wstrb[p] = wstrb; req_wdata[p] = wdata; req_valid[p] = 1;
      acc = -1;
      for (int i = 0; i < 40 && acc < 0; i++) begin
         @(negedge clk);
         if (req_ready[p]) acc = cyc;
      end
      @(posedge clk);
      #1 req_valid[p] = 0;
      n_chk++;
      if (acc < 0) begin
         n_fail++;
         $display("FAIL accept: port %0d addr %h got no req_ready in 40 cycles", p, addr);
         return;
      end
      if (!m_open) begin
         exp_ras.push_back('{acc + 1, row, 4'hf, 32'h0});
         cas_at = acc + 1 + T_RCD;
      end else if (m_row != row) begin
         exp_ras.push_back('{acc + 1, m_row, 4'h0, 32'h0});
         exp_ras.push_back('{acc + 1 + T_RP, row, 4'hf, 32'h0});
         cas_at = acc + 1 + T_RP + T_RCD;
      end else cas_at = acc + 1;
      rsp_at = wr ? cas_at + T_WR : cas_at + LAT + 1;
      exp_d = rmem_rd(k);
      if (wr) for (int b = 0; b < 4; b++) if (!wstrb[b]) exp_d[8*b +: 8] = wdata[8*b +: 8];
      got = -1;
      for (int i = 0; i < 100 && got < 0; i++) begin
         @(negedge clk);
         if (rsp_valid[p]) got = cyc;
      end
      n_chk++;
      if (got != rsp_at) begin
         n_fail++;
         $display("FAIL rsp_cycle: port %0d addr %h rsp at %0d, expected %0d", p, addr, got, rsp_at);
      end
      if (!wr) begin
         n_chk++;
         if (rsp_rdata !== exp_d) begin
            n_fail++;
            $display("FAIL rdata: addr %h got %h expected %h", addr, rsp_rdata, exp_d);
         end
      end
      n_chk++;
      if (ras_q.size() != exp_ras.size()) begin
         n_fail++;
         $display("FAIL ras_count: addr %h got %0d RAS pulses expected %0d", addr, ras_q.size(), exp_ras.size());
      end else
         foreach (exp_ras[i]) begin
            n_chk++;
            if (ras_q[i].cyc != exp_ras[i].cyc || ras_q[i].a !== exp_ras[i].a || ras_q[i].wen !== exp_ras[i].wen || ras_q[i].d !== 32'h0) begin
               n_fail++;
               $display("FAIL ras_%0d: got cyc %0d A %h WEn %h, expected cyc %0d A %h WEn %h",
                        i, ras_q[i].cyc, ras_q[i].a, ras_q[i].wen, exp_ras[i].cyc, exp_ras[i].a, exp_ras[i].wen);
            end
         end
      n_chk++;
      if (cas_q.size() != 1) begin
         n_fail++;
         $display("FAIL cas_count: addr %h got %0d CAS pulses expected 1", addr, cas_q.size());
      end else if (cas_q[0].cyc != cas_at || cas_q[0].a !== {1'b0, col} || cas_q[0].wen !== (wr ? wstrb : 4'hf) || cas_q[0].d !== (wr ? wdata : 32'h0)) begin
         n_fail++;
         $display("FAIL cas: got cyc %0d A %h WEn %h D %h, expected cyc %0d A %h WEn %h D %h",
                  cas_q[0].cyc, cas_q[0].a, cas_q[0].wen, cas_q[0].d, cas_at, {1'b0, col}, wr ? wstrb : 4'hf, wr ? wdata : 32'h0);
      end
      if (wr) rmem[k] = exp_d;
      m_open = 1;
      m_row = row;
      m_last = p;
      last_rsp = got;
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      n_chk++;
      if (outs() !== RST_OUTS) begin
         n_fail++;
         $display("FAIL reset_outs: got %h expected %h", outs(), RST_OUTS);
      end
      rst_n = 1;
      @(negedge clk);
      n_chk++;
      if (dram_csn !== 1'b0 || dram_rasn !== 1'b1 || dram_casn !== 1'b1) begin
         n_fail++;
         $display("FAIL out_of_reset: CSn %b RASn %b CASn %b, expected 0 1 1", dram_csn, dram_rasn, dram_casn);
      end
   endtask

   task automatic test_closed_read();
      xact(0, 0, 32'h0000_1008, 4'hf, 32'h0, 0);
   endtask

   task automatic test_row_hit();
      logic [31:0] prev;
      prev = rsp_rdata;
      xact(1, 1, 32'h0000_100C, 4'h0, 32'hDEAD_BEEF, 0);
      n_chk++;
      if (rsp_rdata !== prev) begin
         n_fail++;
         $display("FAIL rdata_hold: got %h after write, expected %h", rsp_rdata, prev);
      end
      xact(0, 0, 32'h0000_100C, 4'hf, 32'h0, 0);
      n_chk++;
      if (rsp_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL readback: got %h expected deadbeef", rsp_rdata);
      end
   endtask

   task automatic test_row_miss();
      xact(0, 0, 32'h0000_3000, 4'hf, 32'h0, 1);
   endtask

   task automatic test_random();
      int p, gap;
      bit wr;
      logic [10:0] row;
      logic [31:0] addr;
      for (int i = 0; i < 12; i++) begin
         p = $urandom_range(0, 1);
         wr = 1'($urandom_range(0, 1));
         row = 11'($urandom_range(0, 2) * 2 + 1);
         addr = {9'b0, row, 10'($urandom_range(0, 3)), 2'b00};
         gap = $urandom_range(0, 7);
         xact(p, wr, addr, 4'($urandom_range(0, 14)), $urandom, gap);
      end
   endtask

   task automatic test_back_to_back();
      int order[$];
      int n_rsp, expp, g;
      int k[2];
      logic [31:0] exp;
      xact(1, 0, 32'h0000_1004, 4'hf, 32'h0, 0);
      @(posedge clk);
      #1;
      twohot = 0;
      n_rsp = 0;
      expp = -1;
      exp = 0;
      k = '{0, 0};
      req_write = 2'b00;
      req_addr[0] = 32'h0000_1000;
      req_addr[1] = 32'h0000_1040;
      req_valid = 2'b11;
      for (int i = 0; i < 400 && n_rsp < 4; i++) begin
         @(negedge clk);
         if (|rsp_valid) begin
            n_chk++;
            if (expp < 0 || rsp_valid !== 2'(1 << expp) || rsp_rdata !== exp) begin
               n_fail++;
               $display("FAIL b2b_rsp: rsp_valid %b rdata %h, expected port %0d data %h", rsp_valid, rsp_rdata, expp, exp);
            end
            n_rsp++;
         end
         if (req_ready[0] ^ req_ready[1]) begin
            g = req_ready[1] ? 1 : 0;
            order.push_back(g);
            expp = g;
            exp = rmem_rd(mkey(req_addr[g][22:12], req_addr[g][11:2]));
            @(posedge clk);
            #1;
            k[g]++;
            req_addr[g] = req_addr[g] + 32'h4;
            if (order.size() == 4) req_valid = 2'b00;
         end
      end
      req_valid = 2'b00;
      last_rsp = cyc;
      n_chk++;
      if (order.size() != 4 || n_rsp != 4) begin
         n_fail++;
         $display("FAIL b2b_count: %0d grants %0d responses, expected 4 and 4", order.size(), n_rsp);
      end else
         foreach (order[i]) begin
            n_chk++;
            if (order[i] != ((1 - m_last) + i) % 2) begin
               n_fail++;
               $display("FAIL b2b_grant_%0d: got port %0d expected %0d", i, order[i], ((1 - m_last) + i) % 2);
            end
         end
      n_chk++;
      if (twohot) begin
         n_fail++;
         $display("FAIL b2b_twohot: req_ready was 2'b11, expected one-hot");
      end
      if (order.size() > 0) m_last = order[order.size() - 1];
      m_open = 1;
      m_row = 11'd1;
   endtask

   task automatic test_auto_close();
      int r;
      xact(0, 0, 32'h0000_1008, 4'hf, 32'h0, 0);
      r = last_rsp;
      ras_q.delete();
      repeat (25) @(negedge clk);
      n_chk++;
      if (ras_q.size() != 1) begin
         n_fail++;
         $display("FAIL autoclose_count: got %0d RAS pulses expected 1", ras_q.size());
      end else if (ras_q[0].cyc != r + IDLE_CLOSE + 1 || ras_q[0].a !== 11'd1 || ras_q[0].wen !== 4'h0) begin
         n_fail++;
         $display("FAIL autoclose_pre: got cyc %0d A %h WEn %h, expected cyc %0d A 001 WEn 0",
                  ras_q[0].cyc, ras_q[0].a, ras_q[0].wen, r + IDLE_CLOSE + 1);
      end
      m_open = 0;
      xact(1, 0, 32'h0000_1010, 4'hf, 32'h0, 0);
   endtask

   task automatic test_close_race();
      xact(0, 0, 32'h0000_1014, 4'hf, 32'h0, IDLE_CLOSE - 1);
   endtask

   task automatic test_reset_mid_rd();
      int base, seen;
      @(posedge clk);
      #1;
      req_write[0] = 0; req_addr[0] = 32'h0000_5020; req_valid[0] = 1;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (req_ready[0]) seen = 1;
      end
      @(posedge clk);
      #1 req_valid[0] = 0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (!dram_casn) seen = 1;
      end
      n_chk++;
      if (!seen) begin
         n_fail++;
         $display("FAIL midrd_cas: no CAS within 40 cycles");
      end
      @(posedge clk);
      #3;
      base = rsp_cnt;
      rst_n = 0;
      #1;
      n_chk++;
      if (outs() !== RST_OUTS) begin
         n_fail++;
         $display("FAIL midrd_reset_outs: got %h expected %h", outs(), RST_OUTS);
      end
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (15) @(negedge clk);
      n_chk++;
      if (rsp_cnt != base) begin
         n_fail++;
         $display("FAIL midrd_no_rsp: %0d responses after abort, expected 0", rsp_cnt - base);
      end
      m_open = 0;
      m_last = 1;
      xact(1, 0, 32'h0000_5020, 4'hf, 32'h0, 0);
   endtask

   initial begin
      test_reset();
      test_closed_read();
      test_row_hit();
      test_row_miss();
      test_random();
      test_back_to_back();
      test_auto_close();
      test_close_race();
      test_reset_mid_rd();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
